// File: rtl/lm32_tlb_assoc.sv
// lm32_tlb_assoc: N-way set-associative LM32 data TLB with ASID tags, R/W permissions,
//   per-set round-robin replacement and a flush / invalidate / flush-by-ASID engine.
// Latency: address_x indexes the way RAMs (one cycle); tag compare and outputs are combinational in M.
// Backpressure: insert/maintenance requests are taken only while busy=0; a command beats an insert.
// Ports: clk_i/rst_i (sync, active-low); enable, stall_x/m, address_x/m, load_q_m/store_q_m, asid
//   (lookup side); upd_* (insert), cmd_* (maintenance); physical_address_m, miss_m, fault_m,
//   fault_addr, stall_request, busy (results and pipeline hold).
module lm32_tlb_assoc #(
  parameter int SETS       = 64,
  parameter int WAYS       = 2,
  parameter int PAGE_SIZE  = 4096,
  parameter int ASID_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  enable,
  input  logic                  stall_x,
  input  logic                  stall_m,
  input  logic [31:0]           address_x,
  input  logic [31:0]           address_m,
  input  logic                  load_q_m,
  input  logic                  store_q_m,
  input  logic [ASID_WIDTH-1:0] asid,
  input  logic                  upd_valid,
  input  logic [31:0]           upd_vaddr,
  input  logic [31:0]           upd_paddr,
  input  logic [1:0]            upd_perm,
  input  logic                  upd_global,
  input  logic                  cmd_valid,
  input  logic [1:0]            cmd_op,
  input  logic [31:0]           cmd_vaddr,
  input  logic [ASID_WIDTH-1:0] cmd_asid,
  output logic [31:0]           physical_address_m,
  output logic                  miss_m,
  output logic                  fault_m,
  output logic [31:0]           fault_addr,
  output logic                  stall_request,
  output logic                  busy
);

  localparam int OFFW = $clog2(PAGE_SIZE);
  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = 32 - OFFW - IDXW;
  localparam int PFNW = 32 - OFFW;
  localparam int VW   = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef struct packed {
    logic                  valid;
    logic                  glob;
    logic [ASID_WIDTH-1:0] asid;
    logic [TAGW-1:0]       tag;
    logic [PFNW-1:0]       pfn;
    logic [1:0]            perm;
  } entry_t;

  typedef enum logic [2:0] {
    S_IDLE, S_FLUSH, S_UPD_RD, S_UPD_WR, S_INV_RD, S_INV_WR, S_ASID_RD, S_ASID_WR
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDXW-1:0]       r_idx;
  logic [IDXW-1:0]       w_idx_nxt;
  logic                  w_accept_cmd;
  logic                  w_accept_upd;

  // Operands shared by insert and maintenance; only one operation is in flight.
  logic [TAGW-1:0]       r_op_tag;
  logic [IDXW-1:0]       r_op_set;
  logic [ASID_WIDTH-1:0] r_op_asid;
  logic [PFNW-1:0]       r_op_pfn;
  logic [1:0]            r_op_perm;
  logic                  r_op_glob;

  logic [VW-1:0]         r_victim [SETS];
  logic [31:0]           r_fault_addr;

  entry_t [WAYS-1:0]     w_rd;
  entry_t [WAYS-1:0]     w_wr_dat;
  logic   [WAYS-1:0]     w_we;
  logic   [IDXW-1:0]     w_wr_idx;
  logic   [IDXW-1:0]     w_rd_idx;
  logic                  w_rd_en;
  entry_t                w_new;

  logic   [WAYS-1:0]     w_op_match;
  logic                  w_match_found;
  logic   [VW-1:0]       w_match_way;
  logic                  w_inv_found;
  logic   [VW-1:0]       w_inv_way;
  logic   [VW-1:0]       w_upd_way;
  logic                  w_victim_adv;
  logic   [VW-1:0]       w_victim_nxt;

  logic                  w_hit;
  logic   [PFNW-1:0]     w_hit_pfn;
  logic   [1:0]          w_hit_perm;

  // Offset bits never take part in translation; index bits of address_m are implied by the set read.
  logic                  w_unused;
  assign w_unused = ^{address_x[OFFW-1:0], address_x[31:OFFW+IDXW], address_m[OFFW+IDXW-1:OFFW],
                      upd_vaddr[OFFW-1:0], upd_paddr[OFFW-1:0], cmd_vaddr[OFFW-1:0]};

  // Way RAMs: one synchronous read port shared between lookup and maintenance, one write port.
  for (genvar g = 0; g < WAYS; g++) begin : g_way
    entry_t r_ram [SETS];
    entry_t r_rd;
    always_ff @(posedge clk_i) begin
      if (w_we[g]) r_ram[w_wr_idx] <= w_wr_dat[g];
      if (w_rd_en) r_rd <= r_ram[w_rd_idx];
    end
    assign w_rd[g] = r_rd;
  end

  // Maintenance reads own the port in the *_RD states; otherwise X-stage lookups use it.
  always_comb begin
    w_rd_en  = !stall_x;
    w_rd_idx = address_x[OFFW+IDXW-1:OFFW];
    case (r_state)
      S_UPD_RD, S_INV_RD: begin w_rd_en = 1'b1; w_rd_idx = r_op_set; end
      S_ASID_RD:          begin w_rd_en = 1'b1; w_rd_idx = r_idx;    end
      default: ;
    endcase
  end

  // Per-way match against the latched operands; lowest matching / lowest invalid way wins.
  always_comb begin
    w_op_match    = '0;
    w_match_found = 1'b0;
    w_match_way   = '0;
    w_inv_found   = 1'b0;
    w_inv_way     = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_rd[w].valid && (w_rd[w].tag == r_op_tag) &&
          (w_rd[w].glob || (w_rd[w].asid == r_op_asid))) begin
        w_op_match[w] = 1'b1;
        w_match_found = 1'b1;
        w_match_way   = VW'(w);
      end
      if (!w_rd[w].valid) begin
        w_inv_found = 1'b1;
        w_inv_way   = VW'(w);
      end
    end
    w_upd_way    = w_match_found ? w_match_way : (w_inv_found ? w_inv_way : r_victim[r_op_set]);
    w_victim_adv = (r_state == S_UPD_WR) && !w_match_found && !w_inv_found;
    w_victim_nxt = (r_victim[r_op_set] == VW'(WAYS - 1)) ? '0 : r_victim[r_op_set] + VW'(1);
  end

  assign w_new = '{valid: 1'b1, glob: r_op_glob, asid: r_op_asid, tag: r_op_tag,
                   pfn: r_op_pfn, perm: r_op_perm};

  // Writes are suppressed while reset is held so an interrupted insert never lands.
  always_comb begin
    w_we     = '0;
    w_wr_dat = '0;
    w_wr_idx = r_idx;
    case (r_state)
      S_FLUSH: w_we = '1;
      S_UPD_WR: begin
        w_wr_idx              = r_op_set;
        w_we[w_upd_way]       = 1'b1;
        w_wr_dat[w_upd_way]   = w_new;
      end
      S_INV_WR: begin
        w_wr_idx = r_op_set;
        for (int w = 0; w < WAYS; w++) begin
          w_wr_dat[w]       = w_rd[w];
          w_wr_dat[w].valid = 1'b0;
          w_we[w]           = w_op_match[w];
        end
      end
      S_ASID_WR: begin
        for (int w = 0; w < WAYS; w++) begin
          w_wr_dat[w]       = w_rd[w];
          w_wr_dat[w].valid = 1'b0;
          w_we[w]           = w_rd[w].valid && !w_rd[w].glob && (w_rd[w].asid == r_op_asid);
        end
      end
      default: ;
    endcase
    if (!rst_i) w_we = '0;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_accept_cmd = 1'b0;
    w_accept_upd = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_accept_cmd = 1'b1;
          case (cmd_op)
            2'b00:   begin w_state_nxt = S_FLUSH;   w_idx_nxt = IDXW'(SETS - 1); end
            2'b01:         w_state_nxt = S_INV_RD;
            2'b10:   begin w_state_nxt = S_ASID_RD; w_idx_nxt = IDXW'(SETS - 1); end
            default:       w_state_nxt = S_IDLE;
          endcase
        end else if (upd_valid) begin
          w_accept_upd = 1'b1;
          w_state_nxt  = S_UPD_RD;
        end
      end
      S_FLUSH: begin
        w_idx_nxt = r_idx - IDXW'(1);
        if (r_idx == '0) w_state_nxt = S_IDLE;
      end
      S_UPD_RD:  w_state_nxt = S_UPD_WR;
      S_UPD_WR:  w_state_nxt = S_IDLE;
      S_INV_RD:  w_state_nxt = S_INV_WR;
      S_INV_WR:  w_state_nxt = S_IDLE;
      S_ASID_RD: w_state_nxt = S_ASID_WR;
      S_ASID_WR: begin
        w_idx_nxt   = r_idx - IDXW'(1);
        w_state_nxt = (r_idx == '0) ? S_IDLE : S_ASID_RD;
      end
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_state      <= S_FLUSH;
      r_idx        <= IDXW'(SETS - 1);
      r_fault_addr <= '0;
      for (int s = 0; s < SETS; s++) r_victim[s] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      if (w_accept_cmd) begin
        r_op_tag  <= cmd_vaddr[31:OFFW+IDXW];
        r_op_set  <= cmd_vaddr[OFFW+IDXW-1:OFFW];
        r_op_asid <= cmd_asid;
      end else if (w_accept_upd) begin
        r_op_tag  <= upd_vaddr[31:OFFW+IDXW];
        r_op_set  <= upd_vaddr[OFFW+IDXW-1:OFFW];
        r_op_asid <= asid;
        r_op_pfn  <= upd_paddr[31:OFFW];
        r_op_perm <= upd_perm;
        r_op_glob <= upd_global;
      end
      if (w_victim_adv) r_victim[r_op_set] <= w_victim_nxt;
      if ((miss_m || fault_m) && !stall_m) r_fault_addr <= address_m;
    end
  end

  // M-stage compare; the lowest hitting way supplies the translation.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_pfn  = '0;
    w_hit_perm = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (w_rd[w].valid && (w_rd[w].tag == address_m[31:OFFW+IDXW]) &&
          (w_rd[w].glob || (w_rd[w].asid == asid))) begin
        w_hit      = 1'b1;
        w_hit_pfn  = w_rd[w].pfn;
        w_hit_perm = w_rd[w].perm;
      end
    end
  end

  assign physical_address_m = (enable && w_hit) ? {w_hit_pfn, address_m[OFFW-1:0]} : address_m;
  assign miss_m        = rst_i && enable && (load_q_m || store_q_m) && !w_hit;
  assign fault_m       = rst_i && enable && w_hit &&
                         ((load_q_m && !w_hit_perm[0]) || (store_q_m && !w_hit_perm[1]));
  assign busy          = !rst_i || (r_state != S_IDLE);
  assign stall_request = busy && enable;
  assign fault_addr    = r_fault_addr;

endmodule

// File: tb/tb_lm32_tlb_assoc.sv
module tb_lm32_tlb_assoc;
  localparam int SETS       = 64;
  localparam int WAYS       = 2;
  localparam int PAGE_SIZE  = 4096;
  localparam int ASID_WIDTH = 8;

  logic clk_i = 1'b0;
  logic rst_i, enable, stall_x, stall_m, load_q_m, store_q_m;
  logic [31:0] address_x, address_m, upd_vaddr, upd_paddr, cmd_vaddr;
  logic [ASID_WIDTH-1:0] asid, cmd_asid;
  logic upd_valid, upd_global, cmd_valid;
  logic [1:0] upd_perm, cmd_op;
  logic [31:0] physical_address_m, fault_addr;
  logic miss_m, fault_m, stall_request, busy;

  always #5 clk_i = ~clk_i;

  lm32_tlb_assoc #(.SETS(SETS), .WAYS(WAYS), .PAGE_SIZE(PAGE_SIZE), .ASID_WIDTH(ASID_WIDTH)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable(enable), .stall_x(stall_x), .stall_m(stall_m),
    .address_x(address_x), .address_m(address_m), .load_q_m(load_q_m), .store_q_m(store_q_m),
    .asid(asid), .upd_valid(upd_valid), .upd_vaddr(upd_vaddr), .upd_paddr(upd_paddr),
    .upd_perm(upd_perm), .upd_global(upd_global), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_vaddr(cmd_vaddr), .cmd_asid(cmd_asid), .physical_address_m(physical_address_m),
    .miss_m(miss_m), .fault_m(fault_m), .fault_addr(fault_addr),
    .stall_request(stall_request), .busy(busy));

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: per set, an array of WAYS entries plus a round-robin pointer.
  bit          m_v   [WAYS][SETS];
  bit          m_g   [WAYS][SETS];
  int unsigned m_as  [WAYS][SETS];
  int unsigned m_tag [WAYS][SETS];
  logic [31:0] m_pa  [WAYS][SETS];
  logic [1:0]  m_perm[WAYS][SETS];
  int          m_vic [SETS];
  logic [31:0] m_fault_addr;

  function automatic int set_of(input logic [31:0] va);
    return int'((va / PAGE_SIZE) % SETS);
  endfunction
  function automatic int unsigned tag_of(input logic [31:0] va);
    return va / (PAGE_SIZE * SETS);
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) m_v[w][s] = 1'b0;
      m_vic[s] = 0;
    end
    m_fault_addr = 32'h0;
  endfunction

  function automatic void model_insert(input logic [31:0] va, input logic [31:0] pa,
                                       input logic [1:0] perm, input bit glob, input int unsigned as);
    int s, way;
    int unsigned t;
    s = set_of(va);
    t = tag_of(va);
    way = -1;
    for (int w = WAYS - 1; w >= 0; w--)
      if (m_v[w][s] && m_tag[w][s] == t && (m_g[w][s] || m_as[w][s] == as)) way = w;
    if (way < 0)
      for (int w = WAYS - 1; w >= 0; w--)
        if (!m_v[w][s]) way = w;
    if (way < 0) begin
      way = m_vic[s];
      m_vic[s] = (m_vic[s] + 1) % WAYS;
    end
    m_v[way][s] = 1'b1;  m_g[way][s] = glob;  m_as[way][s] = as;  m_tag[way][s] = t;
    m_pa[way][s] = pa - (pa % PAGE_SIZE);  m_perm[way][s] = perm;
  endfunction

  function automatic void model_cmd(input logic [1:0] op, input logic [31:0] va, input int unsigned as);
    for (int s = 0; s < SETS; s++)
      for (int w = 0; w < WAYS; w++) begin
        if (op == 2'b00) m_v[w][s] = 1'b0;
        if (op == 2'b01 && s == set_of(va) && m_tag[w][s] == tag_of(va) && (m_as[w][s] == as || m_g[w][s]))
          m_v[w][s] = 1'b0;
        if (op == 2'b10 && !m_g[w][s] && m_as[w][s] == as) m_v[w][s] = 1'b0;
      end
  endfunction

  function automatic void model_lookup(input logic [31:0] va, input int unsigned as, input bit en,
                                       input bit ld, input bit st, output bit e_miss,
                                       output bit e_fault, output logic [31:0] e_pa);
    int s, hw;
    bit hit;
    s = set_of(va);
    hit = 1'b0;
    hw = 0;
    for (int w = 0; w < WAYS; w++)
      if (!hit && m_v[w][s] && m_tag[w][s] == tag_of(va) && (m_g[w][s] || m_as[w][s] == as)) begin
        hit = 1'b1;
        hw = w;
      end
    e_pa    = (en && hit) ? (m_pa[hw][s] | (va % PAGE_SIZE)) : va;
    e_miss  = en && (ld || st) && !hit;
    e_fault = en && hit && ((ld && !m_perm[hw][s][0]) || (st && !m_perm[hw][s][1]));
  endfunction

  // Called at #1 after a negedge; counts consecutive busy cycles (bounded).
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 400) begin
      n++;
      @(negedge clk_i); #1;
    end
  endtask

  task automatic do_insert(input logic [31:0] va, input logic [31:0] pa, input logic [1:0] perm,
                           input bit glob, input int unsigned as);
    int n;
    @(negedge clk_i);
    upd_vaddr = va; upd_paddr = pa; upd_perm = perm; upd_global = glob;
    asid = ASID_WIDTH'(as); upd_valid = 1'b1;
    @(negedge clk_i); upd_valid = 1'b0; #1;
    count_busy(n);
    check_eq("insert_busy_cycles", n, 2);
    model_insert(va, pa, perm, glob, as);
  endtask

  task automatic do_cmd(input logic [1:0] op, input logic [31:0] va, input int unsigned as);
    int n;
    @(negedge clk_i);
    cmd_op = op; cmd_vaddr = va; cmd_asid = ASID_WIDTH'(as); cmd_valid = 1'b1;
    @(negedge clk_i); cmd_valid = 1'b0; #1;
    count_busy(n);
    if (op == 2'b00) check_eq("flush_all_busy", n, SETS);
    if (op == 2'b01) check_eq("inval_busy", n, 2);
    if (op == 2'b10) check_eq("flush_asid_busy", n, 2 * SETS);
    model_cmd(op, va, as);
  endtask

  task automatic lookup(input logic [31:0] va, input int unsigned as, input bit en, input bit ld,
                        input bit st, input bit stm, output bit o_miss, output bit o_fault,
                        output logic [31:0] o_pa);
    bit e_miss, e_fault;
    logic [31:0] e_pa;
    @(negedge clk_i); address_x = va;
    @(negedge clk_i);
    address_m = va; asid = ASID_WIDTH'(as); enable = en; load_q_m = ld; store_q_m = st; stall_m = stm;
    #1;
    model_lookup(va, as, en, ld, st, e_miss, e_fault, e_pa);
    check_eq("miss_m", miss_m, e_miss);
    check_eq("fault_m", fault_m, e_fault);
    check_eq("physical_address_m", physical_address_m, e_pa);
    o_miss = miss_m; o_fault = fault_m; o_pa = physical_address_m;
    if ((e_miss || e_fault) && !stm) m_fault_addr = va;
    @(negedge clk_i);
    load_q_m = 1'b0; store_q_m = 1'b0; stall_m = 1'b0; enable = 1'b1;
    #1 check_eq("fault_addr", fault_addr, m_fault_addr);
  endtask

  function automatic logic [31:0] rand_va();
    int unsigned s, t;
    case ($urandom_range(0, 3))
      0: s = 0;
      1: s = 5;
      2: s = 9;
      default: s = SETS - 1;
    endcase
    t = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFF / (PAGE_SIZE * SETS)) : $urandom_range(0, 3);
    return t * (PAGE_SIZE * SETS) + s * PAGE_SIZE + $urandom_range(0, PAGE_SIZE - 1);
  endfunction

  initial begin
    bit mi, fa;
    logic [31:0] pa;
    int n;
    rst_i = 1'b0; enable = 1'b1; stall_x = 1'b0; stall_m = 1'b0;
    address_x = '0; address_m = '0; load_q_m = 1'b1; store_q_m = 1'b0; asid = '0;
    upd_valid = 1'b0; upd_vaddr = '0; upd_paddr = '0; upd_perm = '0; upd_global = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'b11; cmd_vaddr = '0; cmd_asid = '0;
    model_reset();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i); #1;
    check_eq("rst_busy", busy, 1);
    check_eq("rst_stall_request", stall_request, 1);
    check_eq("rst_miss", miss_m, 0);
    check_eq("rst_fault", fault_m, 0);
    check_eq("rst_fault_addr", fault_addr, 0);
    load_q_m = 1'b0;
    rst_i = 1'b1; #1;
    count_busy(n);
    check_eq("reset_flush_cycles", n, SETS);

    lookup(32'h0000_1234, 0, 1, 1, 0, 0, mi, fa, pa);
    check_eq("tp_empty_miss", mi, 1);

    do_insert(32'h0000_5000, 32'h1234_5000, 2'b01, 0, 3);
    lookup(32'h0000_5ABC, 3, 1, 1, 0, 0, mi, fa, pa);
    check_eq("tp_hit_pa", pa, 32'h1234_5ABC);
    lookup(32'h0000_5ABC, 3, 1, 0, 1, 0, mi, fa, pa);
    check_eq("tp_store_fault", fa, 1);
    lookup(32'h0000_5ABC, 4, 1, 1, 0, 0, mi, fa, pa);
    check_eq("tp_asid_miss", mi, 1);
    lookup(32'h0000_5ABC, 3, 0, 1, 0, 0, mi, fa, pa);
    check_eq("tp_passthru", pa, 32'h0000_5ABC);

    // Round-robin within set 9
    do_insert(32'h0000_9000, 32'h0100_0000, 2'b11, 0, 3);
    do_insert(32'h0004_9000, 32'h0200_0000, 2'b11, 0, 3);
    do_insert(32'h0008_9000, 32'h0300_0000, 2'b11, 0, 3);
    lookup(32'h0000_9010, 3, 1, 1, 0, 0, mi, fa, pa);
    check_eq("rr_first_evicted", mi, 1);
    lookup(32'h0004_9010, 3, 1, 1, 0, 0, mi, fa, pa);
    check_eq("rr_second_kept", mi, 0);
    do_insert(32'h000C_9000, 32'h0400_0000, 2'b11, 0, 3);
    lookup(32'h0004_9010, 3, 1, 1, 0, 0, mi, fa, pa);
    check_eq("rr_ptr_advanced", mi, 1);
    lookup(32'h0008_9010, 3, 1, 0, 1, 0, mi, fa, pa);
    check_eq("rr_third_pa", pa, 32'h0300_0010);

    // Flush by ASID keeps global entries
    do_insert(32'h0010_0000, 32'h0500_0000, 2'b11, 1, 5);
    do_insert(32'h0020_1000, 32'h0600_0000, 2'b11, 0, 5);
    do_cmd(2'b10, 32'h0, 5);
    lookup(32'h0010_0004, 7, 1, 1, 0, 0, mi, fa, pa);
    check_eq("asid_flush_global_kept", mi, 0);
    lookup(32'h0020_1004, 5, 1, 1, 0, 0, mi, fa, pa);
    check_eq("asid_flush_local_gone", mi, 1);

    // Command and insert together: invalidate first, insert after busy falls
    do_insert(32'h0030_2000, 32'h0AAA_A000, 2'b11, 0, 3);
    @(negedge clk_i);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_vaddr = 32'h0030_2000; cmd_asid = 8'd3;
    upd_valid = 1'b1; upd_vaddr = 32'h0030_2000; upd_paddr = 32'hABCD_E000; upd_perm = 2'b11;
    upd_global = 1'b0; asid = 8'd3;
    @(negedge clk_i); cmd_valid = 1'b0; #1;
    count_busy(n);
    check_eq("both_inval_busy", n, 2);
    @(negedge clk_i); upd_valid = 1'b0; #1;
    check_eq("both_upd_accepted", busy, 1);
    count_busy(n);
    model_cmd(2'b01, 32'h0030_2000, 3);
    model_insert(32'h0030_2000, 32'hABCD_E000, 2'b11, 0, 3);
    lookup(32'h0030_2123, 3, 1, 1, 0, 0, mi, fa, pa);
    check_eq("both_new_mapping", pa, 32'hABCD_E123);

    // Reset during UPD_WR
    do_insert(32'h0040_3000, 32'h0777_7000, 2'b11, 0, 3);
    lookup(32'h0040_3008, 3, 1, 1, 0, 0, mi, fa, pa);
    @(negedge clk_i);
    upd_vaddr = 32'h0050_4000; upd_paddr = 32'h0888_8000; upd_perm = 2'b11; upd_global = 1'b0;
    asid = 8'd3; upd_valid = 1'b1;
    @(negedge clk_i); upd_valid = 1'b0;
    @(negedge clk_i); rst_i = 1'b0;
    @(negedge clk_i); #1;
    check_eq("midrst_busy", busy, 1);
    rst_i = 1'b1; #1;
    count_busy(n);
    check_eq("midrst_flush_cycles", n, SETS);
    model_reset();
    check_eq("midrst_fault_addr", fault_addr, 0);
    lookup(32'h0040_3008, 3, 1, 1, 0, 0, mi, fa, pa);
    check_eq("midrst_prior_miss", mi, 1);
    lookup(32'h0050_4008, 3, 1, 1, 0, 0, mi, fa, pa);
    check_eq("midrst_interrupted_miss", mi, 1);

    // Randomized mix against the model
    for (int i = 0; i < 300; i++) begin
      int unsigned r;
      r = $urandom_range(0, 99);
      if (r < 35) begin
        do_insert(rand_va(), $urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 3) == 0,
                  $urandom_range(3, 5));
      end else if (r < 85) begin
        bit ld;
        ld = $urandom_range(0, 1) == 1;
        lookup(rand_va(), $urandom_range(3, 5), $urandom_range(0, 4) != 0, ld,
               !ld && $urandom_range(0, 5) != 0, $urandom_range(0, 5) == 0, mi, fa, pa);
      end else if (r < 92) begin
        do_cmd(2'b01, rand_va(), $urandom_range(3, 5));
      end else if (r < 95) begin
        do_cmd(2'b10, 32'h0, $urandom_range(3, 5));
      end else if (r < 97) begin
        do_cmd(2'b00, 32'h0, 0);
      end else begin
        do_cmd(2'b11, rand_va(), $urandom_range(3, 5));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lm32_tlb_assoc.md
# lm32_tlb_assoc

Parametrised, N-way set-associative data TLB for the LM32 MMU, the successor to the direct-mapped single-way DTLB. It translates the M-stage load/store virtual address to a physical address, tags entries with an address-space ID (ASID) and read/write permissions, and adds per-set round-robin replacement and a maintenance engine for flush-all, invalidate-by-address and flush-by-ASID. It sits between the LM32 load/store unit and the data cache, and stalls the pipeline while maintenance is in progress.

## Interface
- SETS, 64: sets per way; power of two, ≥2.
- WAYS, 2: associativity; power of two, 1..8.
- PAGE_SIZE, 4096: page size in bytes; power of two.
- ASID_WIDTH, 8: ASID width in bits.
- clk_i  in  1  clock; the only clock.
- rst_i  in  1  reset; synchronous, active-low.
- enable  in  1  translation enable; 0 = pass-through, no miss/fault.
- stall_x, stall_m  in  1  pipeline stalls.
- address_x, address_m  in  32  X/M-stage virtual addresses.
- load_q_m, store_q_m  in  1  load/store in M.
- asid  in  ASID_WIDTH  current ASID.
- upd_valid  in  1  insert request; accepted on a cycle with busy=0 and cmd_valid=0.
- upd_vaddr, upd_paddr  in  32  VPN/PFN source; page-offset bits ignored.
- upd_perm  in  2  bit0 = read allowed, bit1 = write allowed.
- upd_global  in  1  entry matches any ASID.
- cmd_valid  in  1  maintenance request; accepted when busy=0.
- cmd_op  in  2  00 = flush all, 01 = invalidate vaddr, 10 = flush ASID, 11 = no-op.
- cmd_vaddr  in  32; cmd_asid  in  ASID_WIDTH  maintenance operands.
- physical_address_m  out  32  translated address.
- miss_m  out  1  no matching valid entry.
- fault_m  out  1  hit without the required permission.
- fault_addr  out  32  address of the last miss/fault.
- stall_request  out  1  pipeline hold.
- busy  out  1  maintenance engine not idle.

## Operation
- Entry = {valid, global, asid, tag, pfn, perm}. One RAM per way, sync read, one read and one write port. Index = VA[log2(PAGE_SIZE)+log2(SETS)-1 : log2(PAGE_SIZE)].
- Lookup: all ways are read at the address_x index when stall_x=0; compare in M against address_m. Hit = valid && tag match && (global || asid match). With multiple hits, the lowest way wins. physical_address_m = {hit PFN, page offset}; pass-through on enable=0 or a miss.
- miss_m = enable && (load_q_m||store_q_m) && !hit. fault_m = enable && hit && ((load_q_m && !perm[0]) || (store_q_m && !perm[1])). Miss and fault are mutually exclusive.
- fault_addr loads address_m on any cycle with miss_m or fault_m and stall_m=0; otherwise it holds.
- FSM states:
  - IDLE.
  - FLUSH: 1 set/cycle, SETS-1 down to 0, writes valid=0 to every way.
  - UPD_RD → UPD_WR.
  - INV_RD → INV_WR.
  - ASID_RD ↔ ASID_WR: 2 cycles/set, sweeping SETS-1 down to 0.
- Insert: UPD_RD reads the set. UPD_WR overwrites the lowest way that matches on tag and (asid || global); otherwise the lowest invalid way; otherwise the way given by the set's victim pointer, which then increments mod WAYS. The pointer is unchanged on an overwrite or an invalid-way fill. Operands are latched on acceptance.
- Invalidate vaddr: clears every way that matches on tag and (asid==cmd_asid || global).
- Flush ASID: clears every valid, non-global entry with asid==cmd_asid. Global entries are kept.
- cmd_op 11 is accepted and returns to IDLE the next cycle.
- cmd_valid and upd_valid together: cmd is accepted and upd is not. The requester holds upd_valid.
- stall_request = busy && enable. Lookups are not valid while busy.

## Timing
- Reset (rst_i low on a clock edge): FSM enters FLUSH at set SETS-1, all victim pointers are cleared, and fault_addr=0. Outputs while in reset: busy=1, stall_request=enable, miss_m=fault_m=0.
- Reset asserted mid-operation aborts the operation and restarts the full flush.
- Flush completes SETS cycles after rst_i deasserts; busy falls on the following cycle.
- Insert and invalidate: busy is high for 2 cycles after acceptance. A translation is usable by an X-stage access issued on the cycle after busy falls.
- Flush all: SETS cycles. Flush ASID: 2·SETS cycles.
- Lookup latency: address_x is registered through the RAM into M. Outputs are combinational in M, with no added cycle.

## Test plan
- Reset then idle: busy stays high for exactly SETS cycles, then any load with enable=1 → miss_m=1 and fault_addr = address_m.
- Insert VA 0x0000_5000 → PA 0x1234_5000, perm=01, asid=3. Load 0x0000_5ABC → physical 0x1234_5ABC, hit. Store to the same address → fault_m=1. Same load with asid=4 → miss_m=1.
- WAYS=2: insert 3 distinct VAs mapping to the same set with no invalids. The third insert replaces way 0 (pointer at 0), and the pointer advances to 1.
- Global entry for asid 5 plus non-global entry for asid 5, then flush ASID 5 → the global entry still hits, the non-global entry misses, and busy is high for 2·SETS cycles.
- cmd_valid (invalidate) and upd_valid in the same cycle → the invalidate runs first, and the insert is accepted after busy falls.
- rst_i asserted during UPD_WR → no entry is written, the flush restarts, and the prior mapping misses after reset.
